id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameters: none; all widths fixed (32-bit datapath, 5-bit register addresses).
REQ-002 elk  in  1  single clock; all state updates on rising edge.
REQ-003 nrst  in  1  reset, asynchronous, active-low.
REQ-004 if_instr  in  32  fetched instruction from the fetch stage.
REQ-005 if_pc4  in  32  PC+4 of if_instr.
REQ-006 if_valid  in  1  if_instr/if_pc4 are valid this cycle.
REQ-007 flush  in  1  branch-taken kill from EX; discards IF/ID and ID/EX contents.
REQ-008 rd_addrA  out  5  register-file read address A = rs of the IF/ID instruction.
REQ-009 rd_addrB  out  5  register-file read address B = rt of the IF/ID instruction.
REQ-010 rd_dataA  in  32  register-file read data A.
REQ-011 rd_dataB  in  32  register-file read data B.
REQ-012 stall  out  1  combinational load-use stall; fetch holds PC and if_* while high.
REQ-013 ex_valid  out  1  ID/EX slot holds a real instruction.
REQ-014 ex_pc4, ex_dataA, ex_dataB, ex_imm  out  32 each  registered PC+4, operands, sign-extended imm16.
REQ-015 ex_rt, ex_wr_addr  out  5 each  registered rt and destination register.
REQ-016 ex_ctrl  out  8  registered {reg_wr, mem_rd, mem_wr, branch, alu_src, alu_op[2:0]}.
REQ-017 ex_illegal  out  1  registered: IF/ID held an unsupported opcode/funct.

Function
REQ-018 IF/ID register (instr, pc4, valid) SHALL load if_* on each rising edge unless stall=1 (hold) or flush=1 (valid<=0).
REQ-019 Decode SHALL be combinational from IF/ID; ID/EX SHALL load decode results, rd_dataA/B sampled at the same edge; latency if_* -> ex_* = 2 edges.
REQ-020 Supported: R-type op 0x00 funct ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A; ADDI 0x08; LW 0x23; SW 0x2B; BEQ 0x04.
REQ-021 alu_op: ADD=000, SUB=001, AND=010, OR=011, SLT=100; ADDI/LW/SW use ADD; BEQ uses SUB.
REQ-022 wr_addr = rd for R-type, rt for ADDI/LW; reg_wr=1 only for those and only if wr_addr != 0.
REQ-023 alu_src=1 for ADDI/LW/SW; mem_rd=1 LW only; mem_wr=1 SW only; branch=1 BEQ only.
REQ-024 ex_imm = {{16{instr[15]}}, instr[15:0]} for every instruction.
REQ-025 Unsupported opcode/funct: ex_illegal=1, ex_ctrl=0, ex_valid=1 (no architectural effect).
REQ-026 stall = IF/ID.valid & ex_valid & mem_rd & ex_wr_addr!=0 & (ex_wr_addr==rs | (uses_rt & ex_wr_addr==rt)); uses_rt for R-type, SW, BEQ.
REQ-027 While stall=1 ID/EX SHALL load a bubble: ex_valid=0, ex_ctrl=0, ex_illegal=0; stall lasts exactly one cycle per hazard.
REQ-028 flush SHALL have priority over stall: IF/ID.valid<=0 and ID/EX<=bubble on that edge.
REQ-029 IF/ID.valid=0 SHALL produce a bubble in ID/EX regardless of instruction bits.

Reset
REQ-030 nrst=0 SHALL immediately clear IF/ID (valid, instr, pc4) and every ex_* output to 0; stall then reads 0.
REQ-031 Release of nrst mid-stream SHALL resume with the first if_* sampled at the next edge; no stale instruction emitted.

Structure
REQ-032 Package id_pkg SHALL hold opcode/funct constants, alu_op encodings and the ex_ctrl bit positions.
REQ-033 Combinational sub-module id_decoder (instr -> ctrl, wr_addr, illegal, uses_rt); id_stage holds both pipeline registers and hazard logic.

Verification
REQ-034 ADD $3,$1,$2 (0x00221820), regs $1=5,$2=7 -> two edges later ex_dataA=5, ex_dataB=7, ex_wr_addr=3, ex_ctrl=8'b1000_0000.
REQ-035 LW $5,4($1) (0x8C250004) then ADD $6,$5,$2 (0x00A23020) -> stall=1 one cycle, one bubble, ADD emitted next cycle.
REQ-036 ADDI $4,$0,-1 (0x2004FFFF) -> ex_imm=0xFFFFFFFF, alu_src=1, ex_wr_addr=4; ADDI $0,$0,1 -> reg_wr=0.
REQ-037 flush=1 coincident with load-use stall -> both stages bubble, stall=0 next cycle.
REQ-038 0xFC000000 -> ex_illegal=1, ex_ctrl=0; nrst pulse mid-stream -> all ex_* 0 before next edge.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode constants for the instruction-decode stage: opcodes, functs,
// ALU operation encodings and the bit layout of the ex_ctrl bundle.
package id_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b100
   } alu_op_e;

   // ex_ctrl = {reg_wr, mem_rd, mem_wr, branch, alu_src, alu_op[2:0]}
   localparam int CTRL_REG_WR     = 7;
   localparam int CTRL_MEM_RD     = 6;
   localparam int CTRL_MEM_WR     = 5;
   localparam int CTRL_BRANCH     = 4;
   localparam int CTRL_ALU_SRC    = 3;
   localparam int CTRL_ALU_OP_LSB = 0;

endpackage

// File: rtl/id_decoder.sv
// Pure combinational instruction decoder: control bundle, destination register,
// illegal flag, and whether the instruction reads rt (for hazard detection).
module id_decoder
   import id_pkg::*;
(
   input  logic [31:0] instr,
   output logic [7:0]  ctrl,
   output logic [4:0]  wr_addr,
   output logic        illegal,
   output logic        uses_rt
);

   logic [5:0] op;
   logic [5:0] funct;
   logic [4:0] rt;
   logic [4:0] rd;
   logic       reg_wr;
   logic       mem_rd;
   logic       mem_wr;
   logic       branch;
   logic       alu_src;
   alu_op_e    alu_op;
   logic       unused_fields;

   assign op    = instr[31:26];
   assign funct = instr[5:0];
   assign rt    = instr[20:16];
   assign rd    = instr[15:11];

   // rs and shamt are not needed to decode control
   assign unused_fields = ^{instr[25:21], instr[10:6]};

   always_comb begin
      reg_wr  = 1'b0;
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      branch  = 1'b0;
      alu_src = 1'b0;
      alu_op  = ALU_ADD;
      wr_addr = 5'd0;
      illegal = 1'b0;
      uses_rt = 1'b0;
      unique case (op)
         OP_RTYPE: begin
            uses_rt = 1'b1;
            reg_wr  = 1'b1;
            wr_addr = rd;
            unique case (funct)
               FN_ADD:  alu_op = ALU_ADD;
               FN_SUB:  alu_op = ALU_SUB;
               FN_AND:  alu_op = ALU_AND;
               FN_OR:   alu_op = ALU_OR;
               FN_SLT:  alu_op = ALU_SLT;
               default: illegal = 1'b1;
            endcase
         end
         OP_ADDI: begin
            reg_wr  = 1'b1;
            alu_src = 1'b1;
            wr_addr = rt;
         end
         OP_LW: begin
            reg_wr  = 1'b1;
            mem_rd  = 1'b1;
            alu_src = 1'b1;
            wr_addr = rt;
         end
         OP_SW: begin
            uses_rt = 1'b1;
            mem_wr  = 1'b1;
            alu_src = 1'b1;
         end
         OP_BEQ: begin
            uses_rt = 1'b1;
            branch  = 1'b1;
            alu_op  = ALU_SUB;
         end
         default: illegal = 1'b1;
      endcase

      if (wr_addr == 5'd0) reg_wr = 1'b0;

      ctrl                                = 8'd0;
      ctrl[CTRL_REG_WR]                   = reg_wr;
      ctrl[CTRL_MEM_RD]                   = mem_rd;
      ctrl[CTRL_MEM_WR]                   = mem_wr;
      ctrl[CTRL_BRANCH]                   = branch;
      ctrl[CTRL_ALU_SRC]                  = alu_src;
      ctrl[CTRL_ALU_OP_LSB +: 3]          = alu_op;

      // an illegal instruction must have no architectural effect downstream
      if (illegal) begin
         ctrl    = 8'd0;
         wr_addr = 5'd0;
      end
   end

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID and ID/EX pipeline registers, register-file read
// addressing and load-use hazard stall.
module id_stage
   import id_pkg::*;
(
   input  logic        elk,
   input  logic        nrst,
   input  logic [31:0] if_instr,
   input  logic [31:0] if_pc4,
   input  logic        if_valid,
   input  logic        flush,
   output logic [4:0]  rd_addrA,
   output logic [4:0]  rd_addrB,
   input  logic [31:0] rd_dataA,
   input  logic [31:0] rd_dataB,
   output logic        stall,
   output logic        ex_valid,
   output logic [31:0] ex_pc4,
   output logic [31:0] ex_dataA,
   output logic [31:0] ex_dataB,
   output logic [31:0] ex_imm,
   output logic [4:0]  ex_rt,
   output logic [4:0]  ex_wr_addr,
   output logic [7:0]  ex_ctrl,
   output logic        ex_illegal
);

   logic        ifid_valid;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc4;

   logic [7:0]  dec_ctrl;
   logic [4:0]  dec_wr_addr;
   logic        dec_illegal;
   logic        dec_uses_rt;
   logic        bubble;

   id_decoder u_dec (
      .instr   (ifid_instr),
      .ctrl    (dec_ctrl),
      .wr_addr (dec_wr_addr),
      .illegal (dec_illegal),
      .uses_rt (dec_uses_rt)
   );

   assign rd_addrA = ifid_instr[25:21];
   assign rd_addrB = ifid_instr[20:16];

   // load in EX whose result is consumed by the instruction in ID
   assign stall = ifid_valid & ex_valid & ex_ctrl[CTRL_MEM_RD] & (ex_wr_addr != 5'd0) &
                  ((ex_wr_addr == rd_addrA) | (dec_uses_rt & (ex_wr_addr == rd_addrB)));

   assign bubble = flush | stall | ~ifid_valid;

   always_ff @(posedge elk or negedge nrst) begin
      if (!nrst) begin
         ifid_valid <= 1'b0;
         ifid_instr <= 32'd0;
         ifid_pc4   <= 32'd0;
      end else if (flush) begin
         ifid_valid <= 1'b0;
      end else if (!stall) begin
         ifid_valid <= if_valid;
         ifid_instr <= if_instr;
         ifid_pc4   <= if_pc4;
      end
   end

   always_ff @(posedge elk or negedge nrst) begin
      if (!nrst) begin
         ex_valid   <= 1'b0;
         ex_pc4     <= 32'd0;
         ex_dataA   <= 32'd0;
         ex_dataB   <= 32'd0;
         ex_imm     <= 32'd0;
         ex_rt      <= 5'd0;
         ex_wr_addr <= 5'd0;
         ex_ctrl    <= 8'd0;
         ex_illegal <= 1'b0;
      end else if (bubble) begin
         ex_valid   <= 1'b0;
         ex_pc4     <= 32'd0;
         ex_dataA   <= 32'd0;
         ex_dataB   <= 32'd0;
         ex_imm     <= 32'd0;
         ex_rt      <= 5'd0;
         ex_wr_addr <= 5'd0;
         ex_ctrl    <= 8'd0;
         ex_illegal <= 1'b0;
      end else begin
         ex_valid   <= 1'b1;
         ex_pc4     <= ifid_pc4;
         ex_dataA   <= rd_dataA;
         ex_dataB   <= rd_dataB;
         ex_imm     <= {{16{ifid_instr[15]}}, ifid_instr[15:0]};
         ex_rt      <= ifid_instr[20:16];
         ex_wr_addr <= dec_wr_addr;
         ex_ctrl    <= dec_ctrl;
         ex_illegal <= dec_illegal;
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: a transaction-level pipeline model predicts
// each ID/EX slot and the stall flag; a monitor compares what the DUT presents.
module tb_id_stage;

   logic        elk = 1'b0;
   logic        nrst;
   logic [31:0] if_instr;
   logic [31:0] if_pc4;
   logic        if_valid;
   logic        flush;
   logic [4:0]  rd_addrA;
   logic [4:0]  rd_addrB;
   logic [31:0] rd_dataA;
   logic [31:0] rd_dataB;
   logic        stall;
   logic        ex_valid;
   logic [31:0] ex_pc4;
   logic [31:0] ex_dataA;
   logic [31:0] ex_dataB;
   logic [31:0] ex_imm;
   logic [4:0]  ex_rt;
   logic [4:0]  ex_wr_addr;
   logic [7:0]  ex_ctrl;
   logic        ex_illegal;

   always #5 elk = ~elk;

   id_stage dut (
      .elk        (elk),
      .nrst       (nrst),
      .if_instr   (if_instr),
      .if_pc4     (if_pc4),
      .if_valid   (if_valid),
      .flush      (flush),
      .rd_addrA   (rd_addrA),
      .rd_addrB   (rd_addrB),
      .rd_dataA   (rd_dataA),
      .rd_dataB   (rd_dataB),
      .stall      (stall),
      .ex_valid   (ex_valid),
      .ex_pc4     (ex_pc4),
      .ex_dataA   (ex_dataA),
      .ex_dataB   (ex_dataB),
      .ex_imm     (ex_imm),
      .ex_rt      (ex_rt),
      .ex_wr_addr (ex_wr_addr),
      .ex_ctrl    (ex_ctrl),
      .ex_illegal (ex_illegal)
   );

   // register file contents, fixed for the run
   logic [31:0] regs [32];
   assign rd_dataA = regs[rd_addrA];
   assign rd_dataB = regs[rd_addrB];

   typedef struct {
      logic        valid;
      logic [31:0] pc4;
      logic [31:0] da;
      logic [31:0] db;
      logic [31:0] imm;
      logic [4:0]  rt;
      logic [4:0]  wr;
      logic [7:0]  ctrl;
      logic        ill;
      logic        stall;
   } exp_t;

   typedef struct {
      logic        v;
      logic [31:0] instr;
      logic [31:0] pc4;
   } fetch_t;

   exp_t   q[$];
   fetch_t fetch_q[$];
   int     checks = 0;
   int     errors = 0;
   logic [31:0] pc_next = 32'h0000_1004;

   // architectural state of the model: what sits in decode and in execute
   logic        m_if_v = 1'b0;
   logic [31:0] m_if_instr = 32'd0;
   logic [31:0] m_if_pc4 = 32'd0;
   logic        m_ex_v = 1'b0;
   logic        m_ex_load = 1'b0;
   logic [4:0]  m_ex_wr = 5'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
      end
   endtask

   function automatic exp_t bubble_exp();
      exp_t e;
      e.valid = 1'b0; e.pc4 = 32'd0; e.da = 32'd0; e.db = 32'd0; e.imm = 32'd0;
      e.rt = 5'd0; e.wr = 5'd0; e.ctrl = 8'd0; e.ill = 1'b0; e.stall = 1'b0;
      return e;
   endfunction

   // meaning of each supported instruction, straight from the ISA table
   function automatic exp_t decode_ref(input logic [31:0] ins, input logic [31:0] pc4);
      exp_t e;
      logic [5:0] op;
      logic [5:0] fn;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      logic rw, mr, mw, br, as;
      logic [2:0] alu;
      logic [4:0] w;
      op = ins[31:26]; fn = ins[5:0];
      rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
      rw = 0; mr = 0; mw = 0; br = 0; as = 0; alu = 3'd0; w = 5'd0;
      e.valid = 1'b1; e.pc4 = pc4; e.da = regs[rs]; e.db = regs[rt];
      e.imm = {{16{ins[15]}}, ins[15:0]}; e.rt = rt; e.ill = 1'b0; e.stall = 1'b0;
      if (op == 6'h00) begin
         w = rd; rw = 1;
         case (fn)
            6'h20: alu = 3'd0;
            6'h22: alu = 3'd1;
            6'h24: alu = 3'd2;
            6'h25: alu = 3'd3;
            6'h2A: alu = 3'd4;
            default: e.ill = 1'b1;
         endcase
      end else if (op == 6'h08) begin
         w = rt; rw = 1; as = 1;
      end else if (op == 6'h23) begin
         w = rt; rw = 1; mr = 1; as = 1;
      end else if (op == 6'h2B) begin
         mw = 1; as = 1;
      end else if (op == 6'h04) begin
         br = 1; alu = 3'd1;
      end else begin
         e.ill = 1'b1;
      end
      if (w == 5'd0) rw = 0;
      e.ctrl = {rw, mr, mw, br, as, alu};
      e.wr = w;
      if (e.ill) begin
         e.ctrl = 8'd0;
         e.wr = 5'd0;
      end
      return e;
   endfunction

   function automatic logic [31:0] gen_instr();
      int k;
      logic [4:0] rs, rt, rd;
      logic [15:0] imm;
      logic [31:0] r;
      k = $urandom_range(0, 11);
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      imm = 16'($urandom);
      r = $urandom;
      case (k)
         0: return {6'h00, rs, rt, rd, 5'd0, 6'h20};
         1: return {6'h00, rs, rt, rd, 5'd0, 6'h22};
         2: return {6'h00, rs, rt, rd, 5'd0, 6'h24};
         3: return {6'h00, rs, rt, rd, 5'd0, 6'h25};
         4: return {6'h00, rs, rt, rd, 5'd0, 6'h2A};
         5: return {6'h08, rs, rt, imm};
         6, 7: return {6'h23, rs, rt, imm};
         8: return {6'h2B, rs, rt, imm};
         9: return {6'h04, rs, rt, imm};
         10: return {6'h00, rs, rt, rd, 5'd0, 6'h21};
         default: return {6'h3F, r[25:0]};
      endcase
   endfunction

   task automatic push_fetch(input logic v, input logic [31:0] ins);
      fetch_t f;
      f.v = v; f.instr = ins; f.pc4 = pc_next;
      pc_next = pc_next + 32'd4;
      fetch_q.push_back(f);
   endtask

   // One clock: present the fetch head, predict the ID/EX slot, advance the model.
   task automatic step(input logic fl_rand, input logic fl_on_hz);
      logic hz, fl, rt_read;
      logic [5:0] op;
      exp_t e;
      fetch_t f;
      op = m_if_instr[31:26];
      rt_read = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
      hz = m_if_v && m_ex_v && m_ex_load && (m_ex_wr != 5'd0) &&
           ((m_ex_wr == m_if_instr[25:21]) || (rt_read && (m_ex_wr == m_if_instr[20:16])));
      if (fetch_q.size() > 0) f = fetch_q[0];
      else begin
         f.v = 1'b0; f.instr = $urandom; f.pc4 = 32'd0;
      end
      if_valid = f.v;
      if_instr = f.instr;
      if_pc4   = f.pc4;
      fl = fl_on_hz ? hz : (fl_rand && ($urandom_range(0, 11) == 0));
      flush = fl;
      #1;
      if (fl || hz || !m_if_v) e = bubble_exp();
      else e = decode_ref(m_if_instr, m_if_pc4);
      e.stall = hz;
      q.push_back(e);
      @(posedge elk);
      m_ex_v = e.valid;
      m_ex_load = e.valid && (m_if_instr[31:26] == 6'h23);
      m_ex_wr = e.wr;
      if (fl) m_if_v = 1'b0;
      else if (!hz) begin
         m_if_v = f.v; m_if_instr = f.instr; m_if_pc4 = f.pc4;
      end
      if (!hz && fetch_q.size() > 0) void'(fetch_q.pop_front());
      @(negedge elk);
   endtask

   task automatic run_queue(input logic fl_on_hz);
      while (fetch_q.size() > 0) step(1'b0, fl_on_hz);
      repeat (3) step(1'b0, fl_on_hz);
   endtask

   task automatic run_random(input int n);
      for (int i = 0; i < n; i++) begin
         while (fetch_q.size() < 3) push_fetch($urandom_range(0, 99) < 85, gen_instr());
         step(1'b1, 1'b0);
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_ex_valid"}, 32'(ex_valid), 32'd0);
      chk({tag, "_ex_pc4"}, ex_pc4, 32'd0);
      chk({tag, "_ex_dataA"}, ex_dataA, 32'd0);
      chk({tag, "_ex_dataB"}, ex_dataB, 32'd0);
      chk({tag, "_ex_imm"}, ex_imm, 32'd0);
      chk({tag, "_ex_rt"}, 32'(ex_rt), 32'd0);
      chk({tag, "_ex_wr_addr"}, 32'(ex_wr_addr), 32'd0);
      chk({tag, "_ex_ctrl"}, 32'(ex_ctrl), 32'd0);
      chk({tag, "_ex_illegal"}, 32'(ex_illegal), 32'd0);
      chk({tag, "_stall"}, 32'(stall), 32'd0);
   endtask

   // monitor: stall mid-cycle, ID/EX contents just after each edge
   initial begin
      exp_t e;
      forever begin
         @(negedge elk);
         #2;
         if (q.size() > 0) chk("stall", 32'(stall), 32'(q[0].stall));
         @(posedge elk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("ex_valid", 32'(ex_valid), 32'(e.valid));
            chk("ex_ctrl", 32'(ex_ctrl), 32'(e.ctrl));
            chk("ex_illegal", 32'(ex_illegal), 32'(e.ill));
            if (e.valid) begin
               chk("ex_pc4", ex_pc4, e.pc4);
               chk("ex_dataA", ex_dataA, e.da);
               chk("ex_dataB", ex_dataB, e.db);
               chk("ex_imm", ex_imm, e.imm);
               chk("ex_rt", 32'(ex_rt), 32'(e.rt));
               chk("ex_wr_addr", 32'(ex_wr_addr), 32'(e.wr));
            end
         end
      end
   end

   initial begin
      nrst = 1'b0;
      if_instr = 32'd0;
      if_pc4 = 32'd0;
      if_valid = 1'b0;
      flush = 1'b0;
      regs[0] = 32'd0;
      for (int i = 1; i < 32; i++) regs[i] = $urandom;
      regs[1] = 32'd5;
      regs[2] = 32'd7;

      repeat (2) @(negedge elk);
      #1;
      check_all_zero("reset");
      nrst = 1'b1;
      @(negedge elk);

      // ADD $3,$1,$2
      push_fetch(1'b1, 32'h0022_1820);
      run_queue(1'b0);

      // load-use pair, ADDI sign extension, ADDI to $0, illegal opcode
      push_fetch(1'b1, 32'h8C25_0004);
      push_fetch(1'b1, 32'h00A2_3020);
      push_fetch(1'b1, 32'h2004_FFFF);
      push_fetch(1'b1, 32'h2000_0001);
      push_fetch(1'b1, 32'hFC00_0000);
      run_queue(1'b0);

      // flush arriving in the same cycle as the load-use stall
      push_fetch(1'b1, 32'h8C25_0004);
      push_fetch(1'b1, 32'h00A2_3020);
      push_fetch(1'b1, 32'h0022_1820);
      run_queue(1'b1);

      run_random(400);

      // asynchronous reset in the middle of a busy stream
      #3;
      nrst = 1'b0;
      #1;
      check_all_zero("midreset");
      @(negedge elk);
      nrst = 1'b1;
      m_if_v = 1'b0;
      m_ex_v = 1'b0;
      m_ex_load = 1'b0;
      m_ex_wr = 5'd0;

      run_random(300);

      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge elk);
      chk("scoreboard_drained", 32'(q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
